spmi_cmd_decode: RTL
====================

// Module: spmi_cmd_decode
// PURPOSE
//  Downstream consumer of the SPMI receiver (spmi). Takes each 13-bit command frame via packet/valid/fetched.
//  Frame layout: SID[12:9], CMD[8:1], odd parity[0].
//  Checks parity, classifies the command, buffers decoded frames in a small FIFO for the host (ready/valid).
//  Keeps saturating statistics counters.
// PARAMETERS
//  DEPTH      4  FIFO entries, power of 2, >=2
//  DROP_PERR  0  1: parity-error frames are fetched, counted and discarded; 0: pushed with perr=1
// PORTS
//  sysclk      in   1   system clock; only clock
//  reset       in   1   synchronous, active-high
//  packet      in   13  frame from spmi, stable while valid=1
//  valid       in   1   spmi has a frame; held until fetched, then dropped
//  fetched     out  1   one-cycle acknowledge to spmi
//  overflow    in   1   spmi overflow flag (level)
//  out_valid   out  1   FIFO head valid
//  out_ready   in   1   host accepts head when out_valid&out_ready
//  out_sid     out  4   head SID
//  out_cmd     out  8   head command byte
//  out_class   out  4   head command class (spmi_pkg codes)
//  out_perr    out  1   head parity error
//  frame_cnt   out  16  frames fetched, wraps
//  perr_cnt    out  8   parity errors, saturates at 8'hFF
//  ovf_cnt     out  8   overflow rising edges, saturates at 8'hFF
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM=IDLE, counters 0. Asserting reset mid-transfer aborts it.
//  Reset drops fetched at the next edge; a frame being captured is lost.
//  FSM:
//   IDLE: on valid & !full (registered full), go to TAKE at the next edge.
//   TAKE (1 cycle): fetched=1; packet captured/decoded; push unless dropped; frame_cnt++; go to HOLD.
//   HOLD: wait until valid sampled 0, then go to IDLE. A frame is never taken twice.
//  Latency: valid rises in cycle N -> fetched=1 in cycle N+1 -> out_valid=1 in cycle N+2 (FIFO previously empty).
//  fetched is high only in TAKE: exactly one cycle per frame.
//  Parity: perr = ~^packet[12:0] (odd total number of ones passes).
//  Class from CMD:
//   00-0F EXT_WR=0; 10-13 SEQ=1; 14-15 AUTH_MR=2; 16-1F OTHER=8;
//   20-2F EXT_RD=3; 30-37 EXT_WR_L=4; 38-3F EXT_RD_L=5;
//   40-5F REG_WR=6; 60-7F REG_RD=7; 80-FF REG0_WR=9.
//  Back-pressure: while full, remain in IDLE with fetched=0; spmi reports overflow.
//  Full with a pop in the same cycle: no push that cycle; the frame is accepted on a later cycle.
//  Push and pop in the same cycle when not full or empty: both occur, count unchanged.
//  Pop on empty is ignored.
//  Pointers wrap modulo DEPTH; an extra wrap bit distinguishes full from empty.
//  DROP_PERR=1 with perr: fetched still pulses; frame_cnt and perr_cnt increment; no push.
//  ovf_cnt increments on the 0->1 edge of registered overflow.
//  frame_cnt wraps FFFF->0000. perr_cnt and ovf_cnt hold at FF.
// STRUCTURE
//  spmi_pkg: FRAME_W=13, field bit positions, class localparams CLS_*.
//  Sub-module spmi_frame_fifo: sync FIFO of {perr,class,cmd,sid} (17 bits); full/empty/count outputs.
//  Top-level holds the FSM, parity/class decode and counters.
// TESTING
//  1. Frame 13'h2F5 -> one fetched pulse; head SID=1, CMD=7A, class=7, perr=0; frame_cnt=1.
//  2. Frame 13'h1A05 -> SID=D, CMD=02, class=0, perr=0.
//  3. Frame 13'h2F4 -> perr=1, perr_cnt=1; repeat with DROP_PERR=1 -> fetched pulses, out_valid stays 0.
//  4. out_ready=0, send DEPTH+1 frames -> DEPTH fetched pulses; last valid held un-acked.
//     Raise out_ready -> last frame fetched next; order preserved.
//  5. valid held high 10 cycles after fetched -> exactly one push.
//     Pulse overflow 3x -> ovf_cnt=3.
//  6. Reset asserted during TAKE -> fetched low after 1 edge; FIFO empty; all counters 0.

Source files
------------

// File: rtl/spmi_cmd_decode_pkg.sv
// Shared frame layout, command class codes, FSM states and decode helpers
// for the SPMI command decoder.
package spmi_cmd_decode_pkg;

  localparam int FRAME_W = 13;
  localparam int SID_MSB = 12;
  localparam int SID_LSB = 9;
  localparam int CMD_MSB = 8;
  localparam int CMD_LSB = 1;
  localparam int ENTRY_W = 17;

  localparam logic [3:0] CLS_EXT_WR   = 4'd0;
  localparam logic [3:0] CLS_SEQ      = 4'd1;
  localparam logic [3:0] CLS_AUTH_MR  = 4'd2;
  localparam logic [3:0] CLS_EXT_RD   = 4'd3;
  localparam logic [3:0] CLS_EXT_WR_L = 4'd4;
  localparam logic [3:0] CLS_EXT_RD_L = 4'd5;
  localparam logic [3:0] CLS_REG_WR   = 4'd6;
  localparam logic [3:0] CLS_REG_RD   = 4'd7;
  localparam logic [3:0] CLS_OTHER    = 4'd8;
  localparam logic [3:0] CLS_REG0_WR  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TAKE = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic       perr;
    logic [3:0] cls;
    logic [7:0] cmd;
    logic [3:0] sid;
  } entry_t;

  // Odd parity over the whole frame: an even number of ones is an error.
  function automatic logic parity_err(input logic [FRAME_W-1:0] frame);
    return ~^frame;
  endfunction

  function automatic logic [3:0] cmd_class(input logic [7:0] cmd);
    logic [3:0] cls;
    if (cmd[7]) begin
      cls = CLS_REG0_WR;
    end else if (cmd[6:5] == 2'b11) begin
      cls = CLS_REG_RD;
    end else if (cmd[6]) begin
      cls = CLS_REG_WR;
    end else if (cmd[5:3] == 3'b111) begin
      cls = CLS_EXT_RD_L;
    end else if (cmd[5:4] == 2'b11) begin
      cls = CLS_EXT_WR_L;
    end else if (cmd[5]) begin
      cls = CLS_EXT_RD;
    end else if (!cmd[4]) begin
      cls = CLS_EXT_WR;
    end else if (cmd[3:2] == 2'b00) begin
      cls = CLS_SEQ;
    end else if (cmd[3:1] == 3'b010) begin
      cls = CLS_AUTH_MR;
    end else begin
      cls = CLS_OTHER;
    end
    return cls;
  endfunction

endpackage

// File: rtl/spmi_cmd_decode_fifo.sv
// Synchronous FIFO of decoded frames; pointers carry an extra wrap bit so
// full and empty are told apart without a separate flag.
module spmi_cmd_decode_fifo
  import spmi_cmd_decode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ENTRY_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_do_push;
  logic         w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_count   = r_wptr - r_rptr;
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= {(AW+1){1'b0}};
      r_rptr <= {(AW+1){1'b0}};
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage needs no reset: empty gates everything read from it.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end
  end

endmodule

// File: rtl/spmi_cmd_decode.sv
// Accepts frames from the SPMI receiver, checks parity, classifies the command
// and queues decoded frames for the host, keeping statistics counters.
module spmi_cmd_decode
  import spmi_cmd_decode_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter bit DROP_PERR = 1'b0
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic [FRAME_W-1:0] packet,
  input  logic               valid,
  output logic               fetched,
  input  logic               overflow,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_sid,
  output logic [7:0]         out_cmd,
  output logic [3:0]         out_class,
  output logic               out_perr,
  output logic [15:0]        frame_cnt,
  output logic [7:0]         perr_cnt,
  output logic [7:0]         ovf_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e        r_state;
  state_e        w_state_nxt;
  logic          r_fetched;
  logic          r_ovf_q;
  logic          r_ovf_q2;
  logic [15:0]   r_frame_cnt;
  logic [7:0]    r_perr_cnt;
  logic [7:0]    r_ovf_cnt;
  entry_t        w_entry;
  entry_t        w_head;
  logic          w_take;
  logic          w_perr;
  logic          w_push;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;

  // IDLE only leaves when the registered full flag shows room, so TAKE can always push.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (valid && !w_full) begin
          w_state_nxt = ST_TAKE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_TAKE: w_state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (!valid) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_fetched <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_fetched <= (w_state_nxt == ST_TAKE);
    end
  end

  always_comb begin
    w_take       = (r_state == ST_TAKE);
    w_perr       = parity_err(packet);
    w_entry.sid  = packet[SID_MSB:SID_LSB];
    w_entry.cmd  = packet[CMD_MSB:CMD_LSB];
    w_entry.cls  = cmd_class(packet[CMD_MSB:CMD_LSB]);
    w_entry.perr = w_perr;
    w_push       = w_take && !(DROP_PERR && w_perr);
  end

  spmi_cmd_decode_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .i_clk   (sysclk),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_wdata (w_entry),
    .i_pop   (out_ready),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Statistics: frame count wraps, error and overflow counts stick at 8'hFF.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_frame_cnt <= 16'h0000;
      r_perr_cnt  <= 8'h00;
      r_ovf_cnt   <= 8'h00;
      r_ovf_q     <= 1'b0;
      r_ovf_q2    <= 1'b0;
    end else begin
      r_ovf_q  <= overflow;
      r_ovf_q2 <= r_ovf_q;
      if (w_take) begin
        r_frame_cnt <= r_frame_cnt + 16'h0001;
      end
      if (w_take && w_perr && (r_perr_cnt != 8'hFF)) begin
        r_perr_cnt <= r_perr_cnt + 8'h01;
      end
      if (r_ovf_q && !r_ovf_q2 && (r_ovf_cnt != 8'hFF)) begin
        r_ovf_cnt <= r_ovf_cnt + 8'h01;
      end
    end
  end

  always_comb begin
    fetched   = r_fetched;
    frame_cnt = r_frame_cnt;
    perr_cnt  = r_perr_cnt;
    ovf_cnt   = r_ovf_cnt;
    out_valid = (w_count != {CW{1'b0}});
    if (w_empty) begin
      out_sid   = 4'h0;
      out_cmd   = 8'h00;
      out_class = 4'h0;
      out_perr  = 1'b0;
    end else begin
      out_sid   = w_head.sid;
      out_cmd   = w_head.cmd;
      out_class = w_head.cls;
      out_perr  = w_head.perr;
    end
  end

endmodule
